// File: rtl/alu_operand_loader.sv
// Byte-serial operand entry front end for the 32-bit ALU: a debounced push button steps
// switch bytes into shadow registers and commits A, B and the opcode to the ALU in one edge.
module alu_operand_loader #(
   parameter int DEB_CNT = 1000000,
   parameter int CNT_W   = 20
) (
   input  logic        CLK,
   input  logic        Rst_n,
   input  logic [7:0]  SW,
   input  logic        Btn,
   input  logic        Clr,
   output logic [31:0] AA,
   output logic [31:0] BB,
   output logic [2:0]  ALU_OP,
   output logic        Valid,
   output logic        Commit,
   output logic [3:0]  Phase
);

   typedef enum logic [1:0] {
      S_A    = 2'b00,
      S_B    = 2'b01,
      S_OP   = 2'b10,
      S_DONE = 2'b11
   } state_t;

   // Button conditioning
   logic             btn_meta_reg;
   logic             btn_s_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             deb_reg;
   logic             deb_prev_reg;
   logic             step;

   // Entry state
   state_t       state_reg, state_next;
   logic [1:0]   idx_reg, idx_next;
   logic [31:0]  a_sh_reg, a_sh_next;
   logic [31:0]  b_sh_reg, b_sh_next;
   logic [31:0]  aa_reg, aa_next;
   logic [31:0]  bb_reg, bb_next;
   logic [2:0]   op_reg, op_next;
   logic         valid_reg, valid_next;
   logic         commit_reg, commit_next;

   // The debounced level only follows btn_s after DEB_CNT consecutive disagreeing cycles.
   always_ff @(posedge CLK) begin
      if (!Rst_n) begin
         btn_meta_reg <= 1'b0;
         btn_s_reg    <= 1'b0;
         cnt_reg      <= '0;
         deb_reg      <= 1'b0;
         deb_prev_reg <= 1'b0;
      end else begin
         btn_meta_reg <= Btn;
         btn_s_reg    <= btn_meta_reg;
         deb_prev_reg <= deb_reg;
         if (btn_s_reg == deb_reg) begin
            cnt_reg <= '0;
         end else if (cnt_reg == CNT_W'(DEB_CNT - 1)) begin
            deb_reg <= btn_s_reg;
            cnt_reg <= '0;
         end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
         end
      end
   end

   assign step = deb_reg & ~deb_prev_reg;

   always_ff @(posedge CLK) begin
      if (!Rst_n) begin
         state_reg  <= S_A;
         idx_reg    <= 2'd0;
         a_sh_reg   <= '0;
         b_sh_reg   <= '0;
         aa_reg     <= '0;
         bb_reg     <= '0;
         op_reg     <= '0;
         valid_reg  <= 1'b0;
         commit_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         idx_reg    <= idx_next;
         a_sh_reg   <= a_sh_next;
         b_sh_reg   <= b_sh_next;
         aa_reg     <= aa_next;
         bb_reg     <= bb_next;
         op_reg     <= op_next;
         valid_reg  <= valid_next;
         commit_reg <= commit_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      idx_next    = idx_reg;
      a_sh_next   = a_sh_reg;
      b_sh_next   = b_sh_reg;
      aa_next     = aa_reg;
      bb_next     = bb_reg;
      op_next     = op_reg;
      valid_next  = valid_reg;
      commit_next = 1'b0;

      // Clr restarts entry but never disturbs what the ALU is currently computing on.
      if (Clr) begin
         state_next = S_A;
         idx_next   = 2'd0;
         a_sh_next  = '0;
         b_sh_next  = '0;
      end else if (step) begin
         case (state_reg)
            S_A: begin
               a_sh_next[{idx_reg, 3'b000} +: 8] = SW;
               idx_next = idx_reg + 2'd1;
               if (idx_reg == 2'd3) begin
                  state_next = S_B;
               end
            end
            S_B: begin
               b_sh_next[{idx_reg, 3'b000} +: 8] = SW;
               idx_next = idx_reg + 2'd1;
               if (idx_reg == 2'd3) begin
                  state_next = S_OP;
               end
            end
            S_OP: begin
               aa_next     = a_sh_reg;
               bb_next     = b_sh_reg;
               op_next     = SW[2:0];
               valid_next  = 1'b1;
               commit_next = 1'b1;
               idx_next    = 2'd0;
               state_next  = S_DONE;
            end
            S_DONE: begin
               state_next = S_A;
               idx_next   = 2'd0;
               a_sh_next  = '0;
               b_sh_next  = '0;
            end
            default: begin
               state_next = S_A;
               idx_next   = 2'd0;
            end
         endcase
      end
   end

   assign AA     = aa_reg;
   assign BB     = bb_reg;
   assign ALU_OP = op_reg;
   assign Valid  = valid_reg;
   assign Commit = commit_reg;
   assign Phase  = {state_reg, idx_reg};

endmodule

// File: tb/tb_alu_operand_loader.sv
// Self-checking bench for alu_operand_loader: randomized byte entry compared against a
// position-counting model of the entry sequence.
module tb_alu_operand_loader;

   localparam int DEB_CNT = 4;
   localparam int CNT_W   = 3;

   logic        CLK = 1'b0;
   logic        Rst_n;
   logic [7:0]  SW;
   logic        Btn;
   logic        Clr;
   logic [31:0] AA;
   logic [31:0] BB;
   logic [2:0]  ALU_OP;
   logic        Valid;
   logic        Commit;
   logic [3:0]  Phase;

   int checks = 0;
   int errors = 0;

   // Model: position 0..3 = A bytes, 4..7 = B bytes, 8 = opcode, 9 = done.
   int          model_pos;
   logic [7:0]  model_a [4];
   logic [7:0]  model_b [4];
   logic [31:0] exp_aa;
   logic [31:0] exp_bb;
   logic [2:0]  exp_op;
   logic        exp_valid;

   alu_operand_loader #(.DEB_CNT(DEB_CNT), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .Rst_n(Rst_n), .SW(SW), .Btn(Btn), .Clr(Clr),
      .AA(AA), .BB(BB), .ALU_OP(ALU_OP), .Valid(Valid), .Commit(Commit), .Phase(Phase)
   );

   always #5 CLK = ~CLK;

   function automatic logic [3:0] exp_phase();
      if (model_pos < 4) return {2'b00, 2'(model_pos)};
      if (model_pos < 8) return {2'b01, 2'(model_pos - 4)};
      if (model_pos == 8) return 4'b1000;
      return 4'b1100;
   endfunction

   task automatic model_clear_entry();
      model_pos = 0;
      for (int i = 0; i < 4; i++) begin
         model_a[i] = 8'h00;
         model_b[i] = 8'h00;
      end
   endtask

   task automatic model_reset();
      model_clear_entry();
      exp_aa = 32'h0;
      exp_bb = 32'h0;
      exp_op = 3'h0;
      exp_valid = 1'b0;
   endtask

   task automatic model_step(input logic [7:0] sw);
      if (model_pos < 4) begin
         model_a[model_pos] = sw;
         model_pos++;
      end else if (model_pos < 8) begin
         model_b[model_pos - 4] = sw;
         model_pos++;
      end else if (model_pos == 8) begin
         exp_aa = {model_a[3], model_a[2], model_a[1], model_a[0]};
         exp_bb = {model_b[3], model_b[2], model_b[1], model_b[0]};
         exp_op = sw[2:0];
         exp_valid = 1'b1;
         model_pos = 9;
      end else begin
         model_clear_entry();
      end
   endtask

   // Clean press: 10 cycles held, 10 released; optionally Clr held across the step.
   task automatic press(input logic [7:0] sw, input bit with_clr, output int commits);
      commits = 0;
      SW = sw;
      Btn = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (Commit === 1'b1) commits++;
         if (i == 9) Btn = 1'b0;
         if (with_clr && i == 2) Clr = 1'b1;
         if (with_clr && i == 9) Clr = 1'b0;
      end
      SW = 8'($urandom);
      if (with_clr) model_clear_entry();
      else model_step(sw);
   endtask

   task automatic pulse_clr();
      Clr = 1'b1;
      @(negedge CLK);
      Clr = 1'b0;
      model_clear_entry();
   endtask

   task automatic test_reset();
      Rst_n = 1'b0; Btn = 1'b0; Clr = 1'b0; SW = 8'hA5;
      repeat (2) @(negedge CLK);
      model_reset();
      checks++; if (AA !== 32'h0) begin errors++; $display("FAIL reset_aa: got %h expected 00000000", AA); end
      checks++; if (BB !== 32'h0) begin errors++; $display("FAIL reset_bb: got %h expected 00000000", BB); end
      checks++; if (ALU_OP !== 3'h0) begin errors++; $display("FAIL reset_op: got %b expected 000", ALU_OP); end
      checks++; if (Valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", Valid); end
      checks++; if (Commit !== 1'b0) begin errors++; $display("FAIL reset_commit: got %b expected 0", Commit); end
      checks++; if (Phase !== 4'b0000) begin errors++; $display("FAIL reset_phase: got %b expected 0000", Phase); end
      Rst_n = 1'b1;
      @(negedge CLK);
      $display("reset: AA=%h BB=%h OP=%b Valid=%b Phase=%b", AA, BB, ALU_OP, Valid, Phase);
   endtask

   task automatic test_bounce();
      int t;
      int len;
      logic [7:0] sw;
      sw = 8'($urandom);
      SW = sw;
      t = 0;
      while (t < 20) begin
         len = $urandom_range(1, 2);
         Btn = ~Btn;
         repeat (len) @(negedge CLK);
         t += len;
      end
      Btn = 1'b1;
      repeat (50) @(negedge CLK);
      Btn = 1'b0;
      repeat (20) @(negedge CLK);
      model_step(sw);
      checks++; if (Phase !== exp_phase()) begin errors++; $display("FAIL bounce_phase: got %b expected %b", Phase, exp_phase()); end
      checks++; if (Valid !== 1'b0) begin errors++; $display("FAIL bounce_valid: got %b expected 0", Valid); end
      $display("bounce: Phase=%b", Phase);
   endtask

   task automatic test_full_entry();
      logic [7:0] bytes [9];
      int commits;
      int pos_before;
      bytes = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h01, 8'h00, 8'h00, 8'h00, 8'h04};
      pulse_clr();
      for (int k = 0; k < 9; k++) begin
         pos_before = model_pos;
         press(bytes[k], 1'b0, commits);
         checks++; if (commits != ((pos_before == 8) ? 1 : 0)) begin errors++; $display("FAIL full_commit_cnt[%0d]: got %0d expected %0d", k, commits, (pos_before == 8) ? 1 : 0); end
         checks++; if (Phase !== exp_phase()) begin errors++; $display("FAIL full_phase[%0d]: got %b expected %b", k, Phase, exp_phase()); end
         checks++; if (AA !== exp_aa) begin errors++; $display("FAIL full_aa[%0d]: got %h expected %h", k, AA, exp_aa); end
         checks++; if (BB !== exp_bb) begin errors++; $display("FAIL full_bb[%0d]: got %h expected %h", k, BB, exp_bb); end
         checks++; if (ALU_OP !== exp_op) begin errors++; $display("FAIL full_op[%0d]: got %b expected %b", k, ALU_OP, exp_op); end
         checks++; if (Valid !== exp_valid) begin errors++; $display("FAIL full_valid[%0d]: got %b expected %b", k, Valid, exp_valid); end
         $display("full entry step %0d: SW=%h Phase=%b AA=%h BB=%h OP=%b commits=%0d", k, bytes[k], Phase, AA, BB, ALU_OP, commits);
      end
      checks++; if (AA !== 32'h12345678) begin errors++; $display("FAIL full_aa_const: got %h expected 12345678", AA); end
      checks++; if (BB !== 32'h00000001) begin errors++; $display("FAIL full_bb_const: got %h expected 00000001", BB); end
      checks++; if (ALU_OP !== 3'b100) begin errors++; $display("FAIL full_op_const: got %b expected 100", ALU_OP); end
      checks++; if (Phase !== 4'b1100) begin errors++; $display("FAIL full_phase_const: got %b expected 1100", Phase); end
   endtask

   task automatic test_random_entries(input int n);
      int commits;
      int pos_before;
      logic [7:0] sw;
      for (int e = 0; e < n; e++) begin
         for (int k = 0; k < 10; k++) begin
            pos_before = model_pos;
            sw = 8'($urandom);
            press(sw, 1'b0, commits);
            checks++; if (commits != ((pos_before == 8) ? 1 : 0)) begin errors++; $display("FAIL rand_commit_cnt[%0d.%0d]: got %0d expected %0d", e, k, commits, (pos_before == 8) ? 1 : 0); end
            checks++; if (Phase !== exp_phase()) begin errors++; $display("FAIL rand_phase[%0d.%0d]: got %b expected %b", e, k, Phase, exp_phase()); end
            checks++; if (AA !== exp_aa) begin errors++; $display("FAIL rand_aa[%0d.%0d]: got %h expected %h", e, k, AA, exp_aa); end
            checks++; if (BB !== exp_bb) begin errors++; $display("FAIL rand_bb[%0d.%0d]: got %h expected %h", e, k, BB, exp_bb); end
            checks++; if (ALU_OP !== exp_op) begin errors++; $display("FAIL rand_op[%0d.%0d]: got %b expected %b", e, k, ALU_OP, exp_op); end
            checks++; if (Valid !== exp_valid) begin errors++; $display("FAIL rand_valid[%0d.%0d]: got %b expected %b", e, k, Valid, exp_valid); end
            $display("random entry %0d step %0d: SW=%h Phase=%b AA=%h BB=%h OP=%b commits=%0d", e, k, sw, Phase, AA, BB, ALU_OP, commits);
         end
      end
   endtask

   task automatic test_clr_mid_entry();
      int commits;
      while (model_pos != 2) press(8'($urandom), 1'b0, commits);
      @(negedge CLK);
      pulse_clr();
      @(negedge CLK);
      checks++; if (Phase !== 4'b0000) begin errors++; $display("FAIL clr_phase: got %b expected 0000", Phase); end
      checks++; if (AA !== exp_aa) begin errors++; $display("FAIL clr_aa: got %h expected %h", AA, exp_aa); end
      checks++; if (BB !== exp_bb) begin errors++; $display("FAIL clr_bb: got %h expected %h", BB, exp_bb); end
      checks++; if (ALU_OP !== exp_op) begin errors++; $display("FAIL clr_op: got %b expected %b", ALU_OP, exp_op); end
      checks++; if (Valid !== 1'b1) begin errors++; $display("FAIL clr_valid: got %b expected 1", Valid); end
      $display("clr mid entry: Phase=%b AA=%h Valid=%b", Phase, AA, Valid);
      while (model_pos != 9) press(8'($urandom), 1'b0, commits);
      checks++; if (AA !== exp_aa) begin errors++; $display("FAIL clr_fresh_aa: got %h expected %h", AA, exp_aa); end
      checks++; if (BB !== exp_bb) begin errors++; $display("FAIL clr_fresh_bb: got %h expected %h", BB, exp_bb); end
      checks++; if (ALU_OP !== exp_op) begin errors++; $display("FAIL clr_fresh_op: got %b expected %b", ALU_OP, exp_op); end
      $display("fresh entry after clr: AA=%h BB=%h OP=%b", AA, BB, ALU_OP);
   endtask

   task automatic test_clr_on_commit();
      int commits;
      while (model_pos != 8) press(8'($urandom), 1'b0, commits);
      press(8'($urandom), 1'b1, commits);
      checks++; if (commits != 0) begin errors++; $display("FAIL clrop_commit_cnt: got %0d expected 0", commits); end
      checks++; if (Phase !== 4'b0000) begin errors++; $display("FAIL clrop_phase: got %b expected 0000", Phase); end
      checks++; if (AA !== exp_aa) begin errors++; $display("FAIL clrop_aa: got %h expected %h", AA, exp_aa); end
      checks++; if (ALU_OP !== exp_op) begin errors++; $display("FAIL clrop_op: got %b expected %b", ALU_OP, exp_op); end
      $display("clr on opcode step: Phase=%b commits=%0d AA=%h", Phase, commits, AA);
   endtask

   task automatic test_reset_mid_entry();
      int commits;
      while (model_pos != 6) press(8'($urandom), 1'b0, commits);
      Rst_n = 1'b0;
      @(negedge CLK);
      model_reset();
      checks++; if (AA !== 32'h0) begin errors++; $display("FAIL rstmid_aa: got %h expected 00000000", AA); end
      checks++; if (BB !== 32'h0) begin errors++; $display("FAIL rstmid_bb: got %h expected 00000000", BB); end
      checks++; if (ALU_OP !== 3'h0) begin errors++; $display("FAIL rstmid_op: got %b expected 000", ALU_OP); end
      checks++; if (Valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", Valid); end
      checks++; if (Phase !== 4'b0000) begin errors++; $display("FAIL rstmid_phase: got %b expected 0000", Phase); end
      Rst_n = 1'b1;
      @(negedge CLK);
      $display("reset mid entry: AA=%h Valid=%b Phase=%b", AA, Valid, Phase);
   endtask

   initial begin
      test_reset();
      test_bounce();
      test_full_entry();
      test_clr_mid_entry();
      test_clr_on_commit();
      test_random_entries(3);
      test_reset_mid_entry();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
